// File: rtl/smm_stream_adapter.sv
// ============================================================================
// smm_stream_adapter
//
// Streaming front/back end for the Strassen 2x2 matrix multiply core (SMM0).
//
// Matrix elements arrive one per beat on a valid/ready input stream in the
// order A00, A01, A10, A11, B00, B01, B10, B11. They are packed into the
// core's A and B words, block k at bits [k*BLOCKSIZE +: BLOCKSIZE]. Once the
// eighth element is in, the adapter holds A and B stable while the core
// computes, captures the packed C word, and serialises it on a valid/ready
// output stream as C00, C01, C10, C11. m_last marks the C11 beat.
//
// Optional feature (compile-time macro SMM_TILE_COUNT_EN):
//   defined   : tile_count counts completed tiles and wraps at 2^32.
//   undefined : no counter is built and tile_count is tied to zero.
//
// Parameters:
//   DATAWIDTH   : packed width of the A, B and C words (4 blocks)
//   BLOCKSIZE   : width of one matrix element
//   MUL_LATENCY : clock edges from A_out/B_out stable to C_in valid (1..15)
//
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   s_valid    : input element valid
//   s_ready    : adapter accepts an input element (high only in LOAD)
//   s_data     : input element
//   A_out      : packed A word to the core
//   B_out      : packed B word to the core
//   C_in       : packed C word from the core, C00 in the top block
//   m_valid    : output element valid
//   m_ready    : downstream accepts an output element
//   m_data     : output element
//   m_last     : high on the final (C11) output beat of a tile
//   busy       : high whenever the adapter is not in LOAD
//   tile_count : number of completed tiles
// ============================================================================
module smm_stream_adapter #(
    parameter int DATAWIDTH   = 128,
    parameter int BLOCKSIZE   = 32,
    parameter int MUL_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [BLOCKSIZE-1:0] s_data,
    output logic [DATAWIDTH-1:0] A_out,
    output logic [DATAWIDTH-1:0] B_out,
    input  logic [DATAWIDTH-1:0] C_in,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [BLOCKSIZE-1:0] m_data,
    output logic                 m_last,
    output logic                 busy,
    output logic [31:0]          tile_count
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] LATENCY = 4'(MUL_LATENCY);

    state_t                 state;
    logic [2:0]             beat_cnt;
    logic [3:0]             wait_cnt;
    logic [1:0]             out_idx;
    logic [DATAWIDTH-1:0]   result;

    // Output element idx of a packed C word. C00 lives in the top block and
    // C11 in the bottom block, the reverse of how A and B are packed.
    function automatic logic [BLOCKSIZE-1:0] c_block(
        input logic [DATAWIDTH-1:0] c,
        input logic [1:0]           idx
    );
        c_block = c[(3 - int'(idx)) * BLOCKSIZE +: BLOCKSIZE];
    endfunction

    // Main controller. Every output is registered here so the streams see
    // clean, glitch-free handshake signals.
    //
    // LOAD  : each accepted beat is written straight into its block of A_out
    //         (beats 0..3) or B_out (beats 4..7). The word registers are not
    //         cleared between tiles, so they hold the previous tile until the
    //         new beats overwrite them.
    // WAIT  : wait_cnt starts at 0 on the edge that accepted beat 7 and is
    //         compared before it increments, so C_in is captured on the edge
    //         MUL_LATENCY+1 edges after that accept. That gives the core its
    //         full latency measured from the first edge at which A/B are
    //         complete.
    // DRAIN : result holds the captured C word so the core is free to
    //         change C_in; m_data/m_last only move on an accepted beat,
    //         which keeps them stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            beat_cnt <= '0;
            wait_cnt <= '0;
            out_idx  <= '0;
            result   <= '0;
            A_out    <= '0;
            B_out    <= '0;
            s_ready  <= 1'b1;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (s_valid && s_ready) begin
                        if (beat_cnt[2] == 1'b0) begin
                            A_out[int'(beat_cnt[1:0]) * BLOCKSIZE +: BLOCKSIZE] <= s_data;
                        end else begin
                            B_out[int'(beat_cnt[1:0]) * BLOCKSIZE +: BLOCKSIZE] <= s_data;
                        end
                        beat_cnt <= beat_cnt + 3'd1;
                        if (beat_cnt == 3'd7) begin
                            state    <= WAIT;
                            wait_cnt <= '0;
                            s_ready  <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                end

                WAIT: begin
                    wait_cnt <= wait_cnt + 4'd1;
                    if (wait_cnt == LATENCY) begin
                        result  <= C_in;
                        m_data  <= c_block(C_in, 2'd0);
                        m_last  <= 1'b0;
                        m_valid <= 1'b1;
                        out_idx <= '0;
                        state   <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (m_valid && m_ready) begin
                        if (out_idx == 2'd3) begin
                            state    <= LOAD;
                            m_valid  <= 1'b0;
                            m_last   <= 1'b0;
                            s_ready  <= 1'b1;
                            busy     <= 1'b0;
                            beat_cnt <= '0;
                        end else begin
                            out_idx <= out_idx + 2'd1;
                            m_data  <= c_block(result, out_idx + 2'd1);
                            m_last  <= (out_idx == 2'd2);
                        end
                    end
                end

                default: begin
                    state   <= LOAD;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef SMM_TILE_COUNT_EN
    logic tile_done;

    // A tile is complete on the edge that accepts its C11 beat.
    assign tile_done = (state == DRAIN) && m_valid && m_ready && (out_idx == 2'd3);

    // Completed-tile counter. It wraps naturally from 0xFFFFFFFF to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tile_count <= '0;
        end else if (tile_done) begin
            tile_count <= tile_count + 32'd1;
        end
    end
`else
    // Counter not built; the port is kept so the interface never changes.
    assign tile_count = '0;
`endif

endmodule

// File: tb/tb_smm_stream_adapter.sv
// ============================================================================
// tb_smm_stream_adapter
//
// Directed, self-checking bench for smm_stream_adapter. A small behavioural
// model of the SMM0 core (2x2 multiply, C registered once) closes the loop
// between A_out/B_out and C_in. Expected output sequences are hand-computed
// constants.
// ============================================================================
module tb_smm_stream_adapter;

    localparam int DW = 128;
    localparam int BS = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [BS-1:0] s_data;
    logic [DW-1:0] A_out;
    logic [DW-1:0] B_out;
    logic [DW-1:0] C_in;
    logic          m_valid;
    logic          m_ready;
    logic [BS-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic [31:0]   tile_count;

    int errors = 0;
    int checks = 0;
    int exp_tiles = 0;

    logic [31:0] basic_tile [8];
    logic [31:0] ident_tile [8];
    logic [31:0] dbl_tile   [8];
    logic [31:0] basic_exp  [4];
    logic [31:0] ident_exp  [4];
    logic [31:0] dbl_exp    [4];

    smm_stream_adapter #(
        .DATAWIDTH  (DW),
        .BLOCKSIZE  (BS),
        .MUL_LATENCY(1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .A_out     (A_out),
        .B_out     (B_out),
        .C_in      (C_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .tile_count(tile_count)
    );

    always #5 clk = ~clk;

    // Behavioural SMM0: A/B blocks 0..3 are elements 00,01,10,11; the
    // result is packed with C00 in the top block.
    function automatic logic [DW-1:0] smm(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [31:0] a00, a01, a10, a11, b00, b01, b10, b11;
        logic [31:0] c00, c01, c10, c11;
        a00 = a[31:0];  a01 = a[63:32];  a10 = a[95:64];  a11 = a[127:96];
        b00 = b[31:0];  b01 = b[63:32];  b10 = b[95:64];  b11 = b[127:96];
        c00 = a00 * b00 + a01 * b10;
        c01 = a00 * b01 + a01 * b11;
        c10 = a10 * b00 + a11 * b10;
        c11 = a10 * b01 + a11 * b11;
        return {c00, c01, c10, c11};
    endfunction

    // Core model registers its product once per clock.
    always @(posedge clk) begin
        C_in <= smm(A_out, B_out);
    end

    // Expected tile count depends on whether the optional counter is built.
    function automatic logic [31:0] expTileCount();
`ifdef SMM_TILE_COUNT_EN
        return 32'(exp_tiles);
`else
        return 32'd0;
`endif
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Feeds one 8-beat tile, optionally with random idle cycles between
    // beats, then checks the packed A/B words and the WAIT-state flags.
    task automatic applyStimulus(input logic [31:0] beats [8], input bit gaps);
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        for (int j = 0; j < 8; j++) begin
            if (gaps) begin
                int idle;
                idle = int'($urandom_range(0, 2));
                for (int g = 0; g < idle; g++) begin
                    s_valid = 1'b0;
                    s_data  = $urandom;
                    @(posedge clk); #1;
                    checkOutput("s_ready gap", {127'd0, s_ready}, 128'd1);
                end
            end
            checkOutput("s_ready load", {127'd0, s_ready}, 128'd1);
            checkOutput("busy load", {127'd0, busy}, 128'd0);
            s_valid = 1'b1;
            s_data  = beats[j];
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_data  = '0;
        exp_a = {beats[3], beats[2], beats[1], beats[0]};
        exp_b = {beats[7], beats[6], beats[5], beats[4]};
        checkOutput("A_out packed", A_out, exp_a);
        checkOutput("B_out packed", B_out, exp_b);
        checkOutput("s_ready wait", {127'd0, s_ready}, 128'd0);
        checkOutput("busy wait", {127'd0, busy}, 128'd1);
    endtask

    // Collects output beats, stalling each for 'stall' cycles, and returns
    // after 'stop_after' accepted beats. Called right after applyStimulus,
    // so the count of idle samples before m_valid measures capture latency.
    task automatic drainTile(input logic [31:0] expv [4], input int stall, input int stop_after);
        int idx    = 0;
        int held   = 0;
        int idle   = 0;
        int budget = 0;
        bit seen   = 1'b0;
        bit fire;
        while (idx < stop_after && budget < 300) begin
            fire = 1'b0;
            if (m_valid) begin
                seen = 1'b1;
                checkOutput("m_data", {96'd0, m_data}, {96'd0, expv[idx]});
                checkOutput("m_last", {127'd0, m_last}, {127'd0, (idx == 3)});
                checkOutput("s_ready drain", {127'd0, s_ready}, 128'd0);
                checkOutput("busy drain", {127'd0, busy}, 128'd1);
                if (held < stall) begin
                    m_ready = 1'b0;
                    held++;
                end else begin
                    m_ready = 1'b1;
                    fire    = 1'b1;
                end
            end else begin
                if (seen) begin
                    checkOutput("m_valid held", {127'd0, m_valid}, 128'd1);
                end else begin
                    idle++;
                    checkOutput("busy wait", {127'd0, busy}, 128'd1);
                end
                m_ready = (stall == 0);
            end
            @(posedge clk); #1;
            budget++;
            if (fire) begin
                idx++;
                held = 0;
            end
        end
        m_ready = 1'b0;
        checkOutput("beats drained", 128'(idx), 128'(stop_after));
        checkOutput("capture latency", 128'(idle), 128'd2);
        if (stop_after == 4) begin
            exp_tiles++;
            checkOutput("s_ready after tile", {127'd0, s_ready}, 128'd1);
            checkOutput("busy after tile", {127'd0, busy}, 128'd0);
            checkOutput("m_valid after tile", {127'd0, m_valid}, 128'd0);
            checkOutput("m_last after tile", {127'd0, m_last}, 128'd0);
            checkOutput("tile_count", {96'd0, tile_count}, {96'd0, expTileCount()});
        end
    endtask

    // Checks every output against its reset value.
    task automatic checkResetState(input string tag);
        checkOutput({tag, " s_ready"}, {127'd0, s_ready}, 128'd1);
        checkOutput({tag, " m_valid"}, {127'd0, m_valid}, 128'd0);
        checkOutput({tag, " m_last"}, {127'd0, m_last}, 128'd0);
        checkOutput({tag, " m_data"}, {96'd0, m_data}, 128'd0);
        checkOutput({tag, " busy"}, {127'd0, busy}, 128'd0);
        checkOutput({tag, " A_out"}, A_out, 128'd0);
        checkOutput({tag, " B_out"}, B_out, 128'd0);
        checkOutput({tag, " tile_count"}, {96'd0, tile_count}, 128'd0);
    endtask

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        basic_tile = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
        ident_tile = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd5, 32'd6, 32'd7, 32'd8};
        dbl_tile   = '{32'd2, 32'd0, 32'd0, 32'd2, 32'd1, 32'd1, 32'd1, 32'd1};
        basic_exp  = '{32'd19, 32'd22, 32'd43, 32'd50};
        ident_exp  = '{32'd5, 32'd6, 32'd7, 32'd8};
        dbl_exp    = '{32'd2, 32'd2, 32'd2, 32'd2};

        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] basic tile");
        applyStimulus(basic_tile, 1'b0);
        drainTile(basic_exp, 0, 4);
        checkOutput("A_out hold", A_out, {32'd4, 32'd3, 32'd2, 32'd1});
        checkOutput("B_out hold", B_out, {32'd8, 32'd7, 32'd6, 32'd5});

        $display("[TB] identity tile");
        applyStimulus(ident_tile, 1'b0);
        drainTile(ident_exp, 0, 4);

        $display("[TB] backpressure");
        applyStimulus(basic_tile, 1'b0);
        drainTile(basic_exp, 5, 4);

        $display("[TB] input gaps and back-to-back tiles");
        applyStimulus(dbl_tile, 1'b1);
        drainTile(dbl_exp, 0, 4);
        applyStimulus(basic_tile, 1'b1);
        drainTile(basic_exp, 0, 4);

        $display("[TB] reset mid-drain");
        applyStimulus(basic_tile, 1'b0);
        drainTile(basic_exp, 1, 2);
        checkOutput("m_valid before reset", {127'd0, m_valid}, 128'd1);
        #2;
        rst = 1'b1;
        #1;
        exp_tiles = 0;
        checkResetState("async reset");
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(ident_tile, 1'b0);
        drainTile(ident_exp, 0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/smm_stream_adapter.md
Name: smm_stream_adapter

Overview:
- Streaming front/back end for the Strassen 2x2 core (SMM0).
- Accepts matrix elements one per beat on a valid/ready input stream and packs them into the core's A and B words.
- Holds A and B stable while the core computes, then captures the packed C result.
- Unpacks C and serialises it onto a valid/ready output stream, one element per beat, with a last flag.

Parameters:
- DATAWIDTH, 128, packed width of the A, B and C words (4 blocks).
- BLOCKSIZE, 32, width of one matrix element / block.
- MUL_LATENCY, 1, clock edges from A_out/B_out stable to C_in valid (the core registers C once); legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input element valid.
- s_ready  out  1  adapter accepts an input element.
- s_data  in  BLOCKSIZE  input element.
- A_out  out  DATAWIDTH  packed A to the core; block k at bits [k*BLOCKSIZE +: BLOCKSIZE].
- B_out  out  DATAWIDTH  packed B to the core; same layout as A_out.
- C_in  in  DATAWIDTH  packed result from the core.
- m_valid  out  1  output element valid.
- m_ready  in  1  downstream accepts an output element.
- m_data  out  BLOCKSIZE  output element.
- m_last  out  1  high on the 4th (final) output beat of a tile.
- busy  out  1  high in every state except LOAD.
- tile_count  out  32  completed tiles (see Optional Feature).

Behaviour:
- Reset values: all outputs 0 except s_ready=1 (LOAD).
  - A_out, B_out, m_data, m_last, m_valid, busy, tile_count are 0.
  - Internal counters are 0 and the state is LOAD.
  - Reset asserted mid-operation aborts the tile immediately; partial data is discarded.
- Input beat order, 8 beats per tile: A00, A01, A10, A11, B00, B01, B10, B11.
  - Beat j (0..3) writes A_out block j.
  - Beat j (4..7) writes B_out block j-4.
- Handshake:
  - A transfer occurs on a rising edge with valid&ready high.
  - Data is held stable while valid is high and ready is low.
  - m_valid never drops without a transfer.
- States:
  - LOAD: s_ready=1; a 3-bit beat counter increments per accepted beat. On accepting beat 7 -> WAIT, with the wait counter cleared.
  - WAIT: s_ready=0. A_out/B_out held; the wait counter increments each cycle. When the wait counter equals MUL_LATENCY, capture C_in into the result register -> DRAIN.
  - DRAIN: m_valid=1.
    - Emit C00 = C_in[4*BLOCKSIZE-1 -: BLOCKSIZE] first, then C01, C10, C11 (bits [BLOCKSIZE-1:0]).
    - Advance only on m_valid&m_ready. m_last=1 on the C11 beat.
    - When C11 is accepted -> LOAD, increment tile_count, and clear the beat counter.
- Capture timing: C_in is sampled exactly MUL_LATENCY+1 edges after the edge that accepted beat 7.
- Back-to-back: s_ready returns high in the cycle after the last output beat is accepted; no input is accepted during WAIT/DRAIN.
- Boundaries:
  - m_ready held low in DRAIN stalls indefinitely, with m_data/m_last stable.
  - s_valid gaps in LOAD simply pause the beat counter.
  - A_out/B_out keep their last tile value until overwritten by the next LOAD beats.
- Arithmetic: no arithmetic on data. tile_count wraps 0xFFFFFFFF -> 0.

Optional Feature:
- Macro: SMM_TILE_COUNT_EN.
- Defined: tile_count is a 32-bit counter of completed tiles as described, cleared by rst.
- Undefined: the counter logic is not built and tile_count is tied to 0. The port always exists.

Test Plan:
- Basic tile, bench wires the adapter to SMM0 with MUL_LATENCY=1, m_ready=1.
  - Stimulus: input 1,2,3,4,5,6,7,8.
  - Required: m_data sequence 19,22,43,50 with m_last on 50; tile_count=1 (macro on).
- Identity tile.
  - Stimulus: A=1,0,0,1 and B=5,6,7,8.
  - Required: outputs 5,6,7,8; busy high from the edge after beat 7 until 8 is accepted.
- Backpressure.
  - Stimulus: same tile as the basic case, m_ready low for 5 cycles on each output beat.
  - Required: each value held stable; order 19,22,43,50 unchanged.
  - Required: s_ready stays 0 until the cycle after 50 is accepted.
- Input gaps plus back-to-back tiles.
  - Stimulus: s_valid toggled randomly; tile A=2,0,0,2 with B=1,1,1,1, then the basic tile.
  - Required: outputs 2,2,2,2 then 19,22,43,50; tile_count=2.
- Reset mid-DRAIN.
  - Stimulus: assert rst after the 22 beat.
  - Required: all outputs 0 and s_ready=1 immediately. A fresh identity tile then produces 5,6,7,8.
- Macro off.
  - Stimulus: repeat the basic tile without SMM_TILE_COUNT_EN.
  - Required: tile_count=0 throughout; data results unchanged.
